// File: rtl/lemmings_pkg.sv
// Shared types and width helpers for the lemming hatch scheduler.
package lemmings_pkg;

    // Top-level scheduler phases.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2
    } sched_state_t;

    // Facing direction of a single walker.
    typedef enum logic {
        DIR_L = 1'b0,
        DIR_R = 1'b1
    } dir_t;

    localparam int MIN_CNT_W = 1;

    // Bits needed for a counter that cycles through 0..count-1.
    function automatic int cntWidth(input int count);
        return (count <= 2) ? MIN_CNT_W : $clog2(count);
    endfunction

    // Bits needed to hold a tally that can reach maxVal.
    function automatic int tallyWidth(input int maxVal);
        return (maxVal < 1) ? MIN_CNT_W : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/lemming_walker_slot.sv
// One lemming slot: release flag, facing direction and registered walk outputs.
module lemming_walker_slot
    import lemmings_pkg::*;
(
    input  logic clk,
    input  logic areset_n,
    input  logic release_i,
    input  logic clear_i,
    input  logic freeze_i,
    input  logic freezeNext_i,
    input  logic bumpLeft_i,
    input  logic bumpRight_i,
    output logic active_o,
    output logic walkLeft_o,
    output logic walkRight_o
);

    logic active_q, active_d;
    dir_t dir_q, dir_d;
    logic walkLeft_q, walkRight_q;

    // Next slot state: clear and release both face left; bumps only act on the facing side and are frozen while digging.
    always_comb begin
        active_d = active_q;
        dir_d    = dir_q;
        if (clear_i) begin
            active_d = 1'b0;
            dir_d    = DIR_L;
        end else if (release_i) begin
            active_d = 1'b1;
            dir_d    = DIR_L;
        end else if (active_q && !freeze_i) begin
            if (dir_q == DIR_L && bumpLeft_i) begin
                dir_d = DIR_R;
            end else if (dir_q == DIR_R && bumpRight_i) begin
                dir_d = DIR_L;
            end
        end
    end

    // Register slot state; walk outputs look ahead at the next grant so they drop in the same cycle the grant rises.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            active_q    <= 1'b0;
            dir_q       <= DIR_L;
            walkLeft_q  <= 1'b0;
            walkRight_q <= 1'b0;
        end else begin
            active_q    <= active_d;
            dir_q       <= dir_d;
            walkLeft_q  <= active_d && !freezeNext_i && (dir_d == DIR_L);
            walkRight_q <= active_d && !freezeNext_i && (dir_d == DIR_R);
        end
    end

    assign active_o    = active_q;
    assign walkLeft_o  = walkLeft_q;
    assign walkRight_o = walkRight_q;

endmodule

// File: rtl/lemmings_hatch_sched.sv
// Hatch scheduler: timed releases, per-slot walkers and a round-robin shared dig tool.
module lemmings_hatch_sched
    import lemmings_pkg::*;
#(
    parameter int N_LEM      = 4,
    parameter int INTERVAL   = 8,
    parameter int DIG_CYCLES = 4
)(
    input  logic                         clk,
    input  logic                         areset_n,
    input  logic                         start,
    input  logic [N_LEM-1:0]             bump_left,
    input  logic [N_LEM-1:0]             bump_right,
    input  logic [N_LEM-1:0]             dig_req,
    output logic [N_LEM-1:0]             active,
    output logic [N_LEM-1:0]             walk_left,
    output logic [N_LEM-1:0]             walk_right,
    output logic [N_LEM-1:0]             dig_grant,
    output logic [$clog2(N_LEM+1)-1:0]   released_cnt,
    output logic                         done
);

    localparam int CNT_W = tallyWidth(N_LEM);
    localparam int TMR_W = cntWidth(INTERVAL);
    localparam int DIG_W = cntWidth(DIG_CYCLES);
    localparam int PTR_W = cntWidth(N_LEM);

    sched_state_t     state_q;
    logic [TMR_W-1:0] timer_q;
    logic [CNT_W-1:0] relCnt_q;
    logic             done_q;
    logic [N_LEM-1:0] grant_q, grant_d;
    logic [DIG_W-1:0] digCnt_q, digCnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             clearAll;
    logic             releaseNow;
    logic [N_LEM-1:0] releaseVec;
    logic [N_LEM-1:0] eligible;
    logic             found;

    // Decode restart and which slot (if any) is released at the coming edge.
    always_comb begin
        clearAll   = (state_q == DONE) && start;
        releaseNow = (state_q == RELEASE) && (timer_q == '0);
        releaseVec = '0;
        for (int i = 0; i < N_LEM; i++) begin
            releaseVec[i] = releaseNow && (relCnt_q == CNT_W'(i));
        end
    end

    // Scheduler FSM with the interval timer, release tally and done flag.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            relCnt_q <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RELEASE;
                        timer_q <= '0;
                    end
                end
                RELEASE: begin
                    if (releaseNow) begin
                        relCnt_q <= relCnt_q + 1'b1;
                        timer_q  <= TMR_W'(INTERVAL - 1);
                        if (relCnt_q == CNT_W'(N_LEM - 1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state_q  <= RELEASE;
                        timer_q  <= '0;
                        relCnt_q <= '0;
                        done_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Round-robin arbiter: pick a new owner when the tool is free or in the holder's last cycle.
    always_comb begin
        grant_d  = grant_q;
        digCnt_d = digCnt_q;
        ptr_d    = ptr_q;
        found    = 1'b0;
        eligible = active & dig_req & ~grant_q;
        if (clearAll) begin
            grant_d  = '0;
            digCnt_d = '0;
            ptr_d    = '0;
        end else if (grant_q == '0 || digCnt_q == DIG_W'(DIG_CYCLES - 1)) begin
            grant_d  = '0;
            digCnt_d = '0;
            for (int off = 0; off < N_LEM; off++) begin
                if (!found && eligible[(int'(ptr_q) + off) % N_LEM]) begin
                    found = 1'b1;
                    grant_d[(int'(ptr_q) + off) % N_LEM] = 1'b1;
                    ptr_d = PTR_W'((int'(ptr_q) + off + 1) % N_LEM);
                end
            end
        end else begin
            digCnt_d = digCnt_q + 1'b1;
        end
    end

    // Register the dig tool owner, hold counter and priority pointer.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            grant_q  <= '0;
            digCnt_q <= '0;
            ptr_q    <= '0;
        end else begin
            grant_q  <= grant_d;
            digCnt_q <= digCnt_d;
            ptr_q    <= ptr_d;
        end
    end

    for (genvar g = 0; g < N_LEM; g++) begin : g_slot
        lemming_walker_slot u_slot (
            .clk          (clk),
            .areset_n     (areset_n),
            .release_i    (releaseVec[g]),
            .clear_i      (clearAll),
            .freeze_i     (grant_q[g]),
            .freezeNext_i (grant_d[g]),
            .bumpLeft_i   (bump_left[g]),
            .bumpRight_i  (bump_right[g]),
            .active_o     (active[g]),
            .walkLeft_o   (walk_left[g]),
            .walkRight_o  (walk_right[g])
        );
    end

    assign dig_grant    = grant_q;
    assign released_cnt = relCnt_q;
    assign done         = done_q;

endmodule
